// File: rtl/truth_table_sweeper.sv
// Sweeps every input vector of a small combinational DUT, captures its truth table
// and reports how it differs from an expected minterm mask.
module truth_table_sweeper #(
    parameter int N_IN   = 4,
    parameter int SETTLE = 2,
    localparam int N_VEC = 1 << N_IN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [N_VEC-1:0]  expected,
    output logic [N_IN-1:0]   dut_in,
    input  logic              dut_f,
    output logic              busy,
    output logic              done,
    output logic [N_VEC-1:0]  tt,
    output logic              match,
    output logic [N_IN:0]     mismatch_count,
    output logic [N_IN-1:0]   first_fail_idx
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_APPLY,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [N_IN-1:0]    idx_q, idx_d;
    logic [3:0]         settle_q, settle_d;
    logic [N_VEC-1:0]   exp_q, exp_d;
    logic [N_VEC-1:0]   tt_q, tt_d;
    logic [N_IN:0]      cnt_q, cnt_d;
    logic [N_IN-1:0]    ff_q, ff_d;
    logic [N_IN-1:0]    din_q, din_d;
    logic               done_q, done_d;
    logic               match_q, match_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            settle_q <= '0;
            exp_q    <= '0;
            tt_q     <= '0;
            cnt_q    <= '0;
            ff_q     <= '0;
            din_q    <= '0;
            done_q   <= 1'b0;
            match_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            settle_q <= settle_d;
            exp_q    <= exp_d;
            tt_q     <= tt_d;
            cnt_q    <= cnt_d;
            ff_q     <= ff_d;
            din_q    <= din_d;
            done_q   <= done_d;
            match_q  <= match_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        settle_d = settle_q;
        exp_d    = exp_q;
        tt_d     = tt_q;
        cnt_d    = cnt_q;
        ff_d     = ff_q;
        din_d    = din_q;
        done_d   = 1'b0;
        match_d  = match_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d  = ST_APPLY;
                    exp_d    = expected;
                    tt_d     = '0;
                    cnt_d    = '0;
                    ff_d     = '0;
                    match_d  = 1'b0;
                    idx_d    = '0;
                    din_d    = '0;
                    settle_d = '0;
                end
            end
            ST_APPLY: begin
                if (abort) begin
                    state_d  = ST_IDLE;
                    match_d  = 1'b0;
                    din_d    = '0;
                    idx_d    = '0;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q + 4'd1;
                    // Sample in the last cycle of the settle window, then move on.
                    if (settle_q == 4'(SETTLE - 1)) begin
                        tt_d[idx_q] = dut_f;
                        if (dut_f != exp_q[idx_q]) begin
                            cnt_d = cnt_q + (N_IN + 1)'(1);
                            if (cnt_q == '0) begin
                                ff_d = idx_q;
                            end
                        end
                        settle_d = '0;
                        if (idx_q == N_IN'(N_VEC - 1)) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                            match_d = (cnt_d == '0);
                        end else begin
                            idx_d = idx_q + N_IN'(1);
                            din_d = idx_q + N_IN'(1);
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign dut_in         = din_q;
    assign busy           = (state_q == ST_APPLY);
    assign done           = done_q;
    assign tt             = tt_q;
    assign match          = match_q;
    assign mismatch_count = cnt_q;
    assign first_fail_idx = ff_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Randomised and directed bench for truth_table_sweeper; the DUT function is a LUT
// indexed by dut_in, and a cycle-level behavioural model is compared every cycle.
module tb_truth_table_sweeper;

    localparam int N  = 16;
    localparam int S  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] expected = '0;
    logic [3:0]  dut_in;
    logic        dut_f;
    logic        busy, done, match;
    logic [15:0] tt;
    logic [4:0]  mismatch_count;
    logic [3:0]  first_fail_idx;

    logic        start1 = 1'b0;
    logic [3:0]  dut_in1;
    logic        dut_f1;
    logic        busy1, done1, match1;
    logic [15:0] tt1;
    logic [4:0]  mismatch_count1;
    logic [3:0]  first_fail_idx1;

    logic [15:0] lut = '0;
    int          errors = 0;
    int          checks = 0;
    bit          cmp_en = 1'b0;

    always #5 clk = ~clk;

    assign dut_f  = lut[dut_in];
    assign dut_f1 = lut[dut_in1];

    truth_table_sweeper #(.N_IN(4), .SETTLE(S)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .expected(expected),
        .dut_in(dut_in), .dut_f(dut_f), .busy(busy), .done(done), .tt(tt),
        .match(match), .mismatch_count(mismatch_count), .first_fail_idx(first_fail_idx)
    );

    truth_table_sweeper #(.N_IN(4), .SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(1'b0), .expected(expected),
        .dut_in(dut_in1), .dut_f(dut_f1), .busy(busy1), .done(done1), .tt(tt1),
        .match(match1), .mismatch_count(mismatch_count1), .first_fail_idx(first_fail_idx1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, req, $time);
        end
    endtask

    // Behavioural model: elapsed cycles since the accepted start select the vector.
    bit          m_busy, m_done, m_match;
    int          m_t, m_nsamp;
    logic [3:0]  m_din;
    logic [15:0] m_tt, m_exp;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_match = 0; m_t = 0; m_nsamp = 0;
            m_din = '0; m_tt = '0; m_exp = '0;
        end else begin
            m_done = 0;
            if (!m_busy) begin
                if (start) begin
                    m_busy = 1; m_t = 0; m_exp = expected; m_tt = '0;
                    m_nsamp = 0; m_din = '0; m_match = 0;
                end
            end else if (abort) begin
                m_busy = 0; m_din = '0; m_match = 0;
            end else begin
                m_t++;
                if (m_t % S == 0) begin
                    int v;
                    v = m_t / S - 1;
                    m_tt[v] = lut[v];
                    m_nsamp = v + 1;
                    if (v == N - 1) begin
                        m_busy = 0; m_done = 1; m_match = (m_tt == m_exp);
                    end else begin
                        m_din = 4'(v + 1);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            logic [15:0] mask, diff;
            int          ff;
            mask = (m_nsamp >= 16) ? 16'hFFFF : ((16'd1 << m_nsamp) - 16'd1);
            diff = (m_tt ^ m_exp) & mask;
            ff = 0;
            for (int i = 15; i >= 0; i--) if (diff[i]) ff = i;
            check("busy", busy, m_busy);
            check("done", done, m_done);
            check("dut_in", dut_in, m_din);
            check("tt", tt, m_tt);
            check("match", match, m_match);
            check("mismatch_count", mismatch_count, $countones(diff));
            check("first_fail_idx", first_fail_idx, ff);
        end
    end

    task automatic sweep(input logic [15:0] l, input logic [15:0] e, input int restart_at,
                         input int abort_at, output int lat, output bit got_done);
        bit rs, ab;
        rs = 0; ab = 0; got_done = 0; lat = 0;
        lut = l; expected = e;
        @(negedge clk);
        start = 1'b1;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            if (ab) begin lat = n; break; end
            if (done) begin got_done = 1; lat = n; break; end
            if (!rs && restart_at >= 0 && dut_in == 4'(restart_at)) begin start = 1'b1; rs = 1; end
            if (!ab && abort_at >= 0 && dut_in == 4'(abort_at)) begin abort = 1'b1; ab = 1; end
        end
        if (lat == 0) check("sweep_timeout", 0, 1);
        $display("sweep lut=%h exp=%h restart_at=%0d abort_at=%0d lat=%0d done=%0b tt=%h match=%0b cnt=%0d ff=%0d",
                 l, e, restart_at, abort_at, lat, got_done, tt, match, mismatch_count, first_fail_idx);
    endtask

    initial begin
        int  lat;
        bit  gd;
        int  n1;

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_dut_in", dut_in, 0);
        check("rst_tt", tt, 0);
        check("rst_cnt", mismatch_count, 0);
        rst_n = 1'b1;
        cmp_en = 1'b1;

        // f = a&b
        sweep(16'hF000, 16'hF000, -1, -1, lat, gd);
        check("and_done", gd, 1);
        check("and_latency", lat, 33);
        check("and_tt", tt, 16'hF000);
        check("and_match", match, 1);
        check("and_cnt", mismatch_count, 0);
        check("and_ff", first_fail_idx, 0);
        repeat (3) @(negedge clk);
        check("done_hold_din", dut_in, 15);
        check("done_hold_tt", tt, 16'hF000);

        // parity with one expected bit flipped
        sweep(16'h6996, 16'h69B6, -1, -1, lat, gd);
        check("xor_tt", tt, 16'h6996);
        check("xor_match", match, 0);
        check("xor_cnt", mismatch_count, 1);
        check("xor_ff", first_fail_idx, 5);

        // start in DONE clears results on the accepted edge
        @(negedge clk); start = 1'b1; lut = '0; expected = 16'hFFFF;
        @(negedge clk); start = 1'b0;
        check("restart_busy", busy, 1);
        check("restart_cnt", mismatch_count, 0);
        check("restart_ff", first_fail_idx, 0);
        n1 = 0;
        while (!done && n1 < 100) begin @(negedge clk); n1++; end
        check("zero_done_seen", done, 1);
        check("zero_cnt", mismatch_count, 16);
        check("zero_ff", first_fail_idx, 0);
        check("zero_match", match, 0);

        // abort at vector 7, then a full clean sweep
        sweep(16'h6996, 16'h6996, -1, 7, lat, gd);
        check("abort_no_done", gd, 0);
        check("abort_busy", busy, 0);
        check("abort_din", dut_in, 0);
        check("abort_tt", tt, 16'h0016);
        sweep(16'h6996, 16'h6996, -1, -1, lat, gd);
        check("post_abort_match", match, 1);
        check("post_abort_latency", lat, 33);

        // start re-pulsed mid-sweep is ignored
        sweep(16'h1234, 16'h1234, 3, -1, lat, gd);
        check("restart_ignored_latency", lat, 33);
        check("restart_ignored_match", match, 1);

        // randomised sweeps
        for (int k = 0; k < 10; k++) begin
            logic [15:0] l, e;
            int ab_at, rs_at;
            l = 16'($urandom);
            e = ($urandom_range(0, 2) == 0) ? l : (l ^ 16'($urandom) & 16'($urandom));
            ab_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1;
            rs_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 15)) : -1;
            sweep(l, e, rs_at, ab_at, lat, gd);
            if (gd) check("rand_latency", lat, 33);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // asynchronous reset mid-sweep
        lut = 16'hA5A5; expected = 16'hA5A5;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n1 = 0;
        while (dut_in != 4'd10 && n1 < 100) begin @(negedge clk); n1++; end
        check("reach_din10", dut_in, 10);
        #2 rst_n = 1'b0;
        #1;
        check("async_busy", busy, 0);
        check("async_din", dut_in, 0);
        check("async_tt", tt, 0);
        check("async_cnt", mismatch_count, 0);
        check("async_done", done, 0);
        @(negedge clk); #2 rst_n = 1'b1;

        // SETTLE=1 instance
        lut = 16'hC3A1; expected = 16'hC3A1;
        @(negedge clk); start1 = 1'b1;
        n1 = 0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            start1 = 1'b0;
            if (done1) begin n1 = n; break; end
        end
        check("s1_latency", n1, 17);
        check("s1_tt", tt1, 16'hC3A1);
        check("s1_match", match1, 1);
        $display("settle1 sweep lat=%0d tt=%h match=%0b", n1, tt1, match1);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequencing controller for the team's 4-input single-output combinational lab functions (inputs a, b, c, d; output f).
- On start, drives all 2^N_IN input vectors in ascending order and holds each for a settle window.
- Samples the function output into a truth-table register and compares it bit-by-bit against an expected minterm mask.
- Sits between the bench/top and the combinational DUT; replaces hand-written vector lists in benches.

Parameters:
- N_IN, default 4: number of DUT inputs; sweep length N_VEC = 2^N_IN.
- SETTLE, default 2: cycles each vector is held before sampling; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin a sweep; honoured only in IDLE or DONE.
- abort  input  1  stops a sweep in progress.
- expected  input  N_VEC  expected minterm mask; bit i = expected f for vector i; latched on accepted start.
- dut_in  output  N_IN  vector driven to the DUT; MSB = a, LSB = d for N_IN=4.
- dut_f  input  1  DUT output f.
- busy  output  1  high while a sweep is active.
- done  output  1  one-cycle pulse when a sweep completes (not on abort).
- tt  output  N_VEC  captured truth table; bit i = sampled f for vector i.
- match  output  1  valid when done=1 and afterwards: 1 iff tt == latched expected.
- mismatch_count  output  N_IN+1  number of differing vectors (0..N_VEC).
- first_fail_idx  output  N_IN  lowest failing vector index; 0 if none.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: all outputs 0 (dut_in=0, busy=0, done=0, tt=0, match=0, mismatch_count=0, first_fail_idx=0). State = IDLE. Internal idx, settle counter and expected latch = 0.
- FSM states: IDLE, APPLY, DONE.
- IDLE/DONE, start=1 at edge k:
  - latch expected; clear tt, mismatch_count, first_fail_idx and match;
  - set idx=0, dut_in=0, settle=0;
  - enter APPLY; busy=1 from cycle k+1.
- APPLY, each cycle:
  - settle increments.
  - When settle == SETTLE-1: tt[idx] <= dut_f. If dut_f != exp[idx], mismatch_count += 1, and first_fail_idx <= idx if this is the first failure.
  - If idx == N_VEC-1, go to DONE. Otherwise idx++, dut_in <= idx+1, settle <= 0.
- Vector timing: each vector is on dut_in for exactly SETTLE cycles. The sample uses dut_f in the last cycle of that window. dut_in is registered; no combinational path from start.
- Entry to DONE: busy=0, done=1 for exactly one cycle, and match <= (mismatch_count_final == 0).
  - Latency from the accepted start edge to done high: N_VEC*SETTLE + 1 cycles (33 for the defaults).
- DONE: holds tt, match, counts and first_fail_idx until the next accepted start. dut_in holds N_VEC-1. Stays in DONE unless start arrives.
- start while busy: ignored; no restart, no effect on counters.
- abort in APPLY:
  - next state IDLE; busy=0; done stays 0; match=0;
  - tt and counts keep their partial values; dut_in returns to 0.
- abort in IDLE/DONE: no effect.
- start and abort in the same cycle:
  - during APPLY, abort wins;
  - in IDLE/DONE, start wins.
- Wrap-around: idx never exceeds N_VEC-1. mismatch_count saturates naturally at N_VEC because of its N_IN+1 width.
- Reset mid-sweep: immediate asynchronous return to reset values; no done pulse.

Test Plan:
- Bench model f = a&b, expected=16'hF000, SETTLE=2, single start pulse -> dut_in steps 0..15 every 2 cycles; done at cycle 33 after start; tt=16'hF000; match=1; mismatch_count=0; first_fail_idx=0.
- Model f = a^b^c^d, expected=16'h6996 with bit 5 flipped (16'h69B6) -> tt=16'h6996, match=0, mismatch_count=1, first_fail_idx=5.
- Model f constant 0, expected=16'hFFFF -> mismatch_count=16, first_fail_idx=0, match=0.
- Abort asserted while dut_in=7 -> busy falls the next cycle; no done pulse; dut_in=0; tt keeps bits 0..6. A following start gives a full correct sweep.
- start re-pulsed at dut_in=3 mid-sweep -> ignored; done still at cycle 33 after the original start. start in DONE -> new sweep; results cleared on the accepted edge.
- rst_n low at dut_in=10 -> all outputs 0 immediately (asynchronously). SETTLE=1 build -> done 17 cycles after start.
